// File: rtl/maxnet_ctrl.sv
// MAXNET competition controller: sequences load/calc/update pulses for a 4-neuron
// winner-take-all datapath and reports the surviving neuron, annihilation or timeout.
module maxnet_ctrl #(
    parameter int MAX_ITER = 31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] zero_flags,
    output logic       ld_init,
    output logic       en_calc,
    output logic       ld_act,
    output logic       busy,
    output logic       done,
    output logic [1:0] winner_idx,
    output logic       winner_valid,
    output logic       timeout,
    output logic [4:0] iter_count
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        CHECK,
        CALC,
        UPDATE,
        DONE
    } state_t;

    localparam logic [4:0] ITER_LIMIT = 5'(MAX_ITER);

    state_t     state;
    logic [2:0] nz;
    logic [1:0] zero_pos;

    // Survivors are the neurons whose zero flag is clear; zero_pos is only meaningful when nz == 1.
    always_comb begin
        nz       = 3'd0;
        zero_pos = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!zero_flags[i]) begin
                nz       = nz + 3'd1;
                zero_pos = 2'(i);
            end
        end
    end

    // Every output is registered and set on entry to the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ld_init      <= 1'b0;
            en_calc      <= 1'b0;
            ld_act       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            winner_idx   <= 2'd0;
            winner_valid <= 1'b0;
            timeout      <= 1'b0;
            iter_count   <= 5'd0;
        end else begin
            ld_init <= 1'b0;
            en_calc <= 1'b0;
            ld_act  <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= INIT;
                        ld_init      <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        winner_idx   <= 2'd0;
                        winner_valid <= 1'b0;
                        timeout      <= 1'b0;
                        iter_count   <= 5'd0;
                    end
                end
                INIT: begin
                    state <= CHECK;
                end
                CHECK: begin
                    if (nz <= 3'd1) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        winner_valid <= (nz == 3'd1);
                        winner_idx   <= (nz == 3'd1) ? zero_pos : 2'd0;
                        timeout      <= 1'b0;
                    end else if (iter_count >= ITER_LIMIT) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        winner_valid <= 1'b0;
                        winner_idx   <= 2'd0;
                        timeout      <= 1'b1;
                    end else begin
                        state   <= CALC;
                        en_calc <= 1'b1;
                    end
                end
                CALC: begin
                    state  <= UPDATE;
                    ld_act <= 1'b1;
                end
                UPDATE: begin
                    state <= CHECK;
                    // CALC is only reached below the limit, so this cannot pass MAX_ITER.
                    if (iter_count < ITER_LIMIT) begin
                        iter_count <= iter_count + 5'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxnet_ctrl.sv
// Directed bench for maxnet_ctrl: default instance plus a MAX_ITER=3 instance
// sharing clock and inputs.
module tb_maxnet_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] zero_flags;

    logic       ld_init, en_calc, ld_act, busy, done, winner_valid, timeout;
    logic [1:0] winner_idx;
    logic [4:0] iter_count;

    logic       ld_init3, en_calc3, ld_act3, busy3, done3, winner_valid3, timeout3;
    logic [1:0] winner_idx3;
    logic [4:0] iter_count3;

    int tests = 0;
    int failures = 0;

    maxnet_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .zero_flags(zero_flags),
        .ld_init(ld_init), .en_calc(en_calc), .ld_act(ld_act), .busy(busy), .done(done),
        .winner_idx(winner_idx), .winner_valid(winner_valid), .timeout(timeout),
        .iter_count(iter_count)
    );

    maxnet_ctrl #(.MAX_ITER(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .zero_flags(zero_flags),
        .ld_init(ld_init3), .en_calc(en_calc3), .ld_act(ld_act3), .busy(busy3), .done(done3),
        .winner_idx(winner_idx3), .winner_valid(winner_valid3), .timeout(timeout3),
        .iter_count(iter_count3)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Runs until the selected instance raises done or the cycle limit expires.
    task automatic wait_done(input bit use3, input int limit, output int cycles,
                             output int acts, output int overlaps, output bit expired);
        cycles = 0;
        acts = 0;
        overlaps = 0;
        expired = 1'b1;
        while (cycles < limit) begin
            tick();
            cycles++;
            if (use3) begin
                acts += int'(ld_act3);
                if (int'(ld_init3) + int'(en_calc3) + int'(ld_act3) > 1) overlaps++;
                if (done3) begin expired = 1'b0; break; end
            end else begin
                acts += int'(ld_act);
                if (int'(ld_init) + int'(en_calc) + int'(ld_act) > 1) overlaps++;
                if (done) begin expired = 1'b0; break; end
            end
        end
    endtask

    task automatic test_reset();
        logic [13:0] outs;
        rst = 1'b1;
        start = 1'b1;
        zero_flags = 4'b0111;
        tick();
        outs = {ld_init, en_calc, ld_act, busy, done, winner_idx, winner_valid, timeout, iter_count};
        tests++;
        if (outs !== 14'd0) begin failures++; $display("[TB] FAIL reset_outputs: got %h expected 0", outs); end
        rst = 1'b0;
        start = 1'b0;
        tick();
        tests++;
        if (ld_init !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_start_ignored: ld_init=%b busy=%b expected 0 0", ld_init, busy); end
    endtask

    task automatic test_first_check_winner();
        int cyc, acts, ovl;
        bit exp_flag;
        do_reset();
        zero_flags = 4'b0111;
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++;
        if (ld_init !== 1'b1 || busy !== 1'b1) begin failures++; $display("[TB] FAIL first_init: ld_init=%b busy=%b expected 1 1", ld_init, busy); end
        wait_done(1'b0, 20, cyc, acts, ovl, exp_flag);
        tests++;
        if (exp_flag || cyc !== 2) begin failures++; $display("[TB] FAIL first_latency: got %0d cycles expected 2 (expired=%b)", cyc, exp_flag); end
        tests++;
        if (winner_idx !== 2'd3 || winner_valid !== 1'b1) begin failures++; $display("[TB] FAIL first_winner: idx=%0d valid=%b expected 3 1", winner_idx, winner_valid); end
        tests++;
        if (iter_count !== 5'd0 || acts !== 0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL first_iters: iter=%0d acts=%0d busy=%b expected 0 0 0", iter_count, acts, busy); end
    endtask

    // Flags only count when sampled in CHECK (edges 3, 6, 9); other edges see decoy values.
    task automatic test_two_iterations();
        int acts = 0;
        int early = 0;
        int ovl = 0;
        do_reset();
        for (int t = 1; t <= 9; t++) begin
            start = (t <= 3);
            zero_flags = (t == 3 || t == 6) ? 4'b0000 : (t == 9) ? 4'b1011 : 4'b1110;
            tick();
            acts += int'(ld_act);
            if (int'(ld_init) + int'(en_calc) + int'(ld_act) > 1) ovl++;
            if (t < 9 && done) early++;
        end
        start = 1'b0;
        tests++;
        if (done !== 1'b1 || early !== 0) begin failures++; $display("[TB] FAIL two_iter_latency: done=%b early=%0d expected 1 0", done, early); end
        tests++;
        if (winner_idx !== 2'd2 || winner_valid !== 1'b1 || timeout !== 1'b0) begin failures++; $display("[TB] FAIL two_iter_winner: idx=%0d valid=%b timeout=%b expected 2 1 0", winner_idx, winner_valid, timeout); end
        tests++;
        if (iter_count !== 5'd2 || acts !== 2 || ovl !== 0) begin failures++; $display("[TB] FAIL two_iter_count: iter=%0d acts=%0d overlaps=%0d expected 2 2 0", iter_count, acts, ovl); end
        zero_flags = 4'b0000;
        tick();
        tests++;
        if (done !== 1'b1 || iter_count !== 5'd2 || winner_idx !== 2'd2) begin failures++; $display("[TB] FAIL two_iter_hold: done=%b iter=%0d idx=%0d expected 1 2 2", done, iter_count, winner_idx); end
    endtask

    task automatic test_timeout_short();
        int cyc, acts, ovl;
        bit exp_flag;
        do_reset();
        zero_flags = 4'b0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1'b1, 40, cyc, acts, ovl, exp_flag);
        tests++;
        if (exp_flag || cyc !== 11) begin failures++; $display("[TB] FAIL timeout3_latency: got %0d cycles expected 11 (expired=%b)", cyc, exp_flag); end
        tests++;
        if (acts !== 3 || iter_count3 !== 5'd3 || ovl !== 0) begin failures++; $display("[TB] FAIL timeout3_count: acts=%0d iter=%0d overlaps=%0d expected 3 3 0", acts, iter_count3, ovl); end
        tests++;
        if (timeout3 !== 1'b1 || winner_valid3 !== 1'b0 || winner_idx3 !== 2'd0) begin failures++; $display("[TB] FAIL timeout3_flags: timeout=%b valid=%b idx=%0d expected 1 0 0", timeout3, winner_valid3, winner_idx3); end
    endtask

    task automatic test_timeout_default();
        int cyc, acts, ovl;
        bit exp_flag;
        do_reset();
        zero_flags = 4'b0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1'b0, 200, cyc, acts, ovl, exp_flag);
        tests++;
        if (exp_flag || cyc !== 95) begin failures++; $display("[TB] FAIL timeout31_latency: got %0d cycles expected 95 (expired=%b)", cyc, exp_flag); end
        tests++;
        if (acts !== 31 || iter_count !== 5'd31 || timeout !== 1'b1 || winner_valid !== 1'b0) begin failures++; $display("[TB] FAIL timeout31_state: acts=%0d iter=%0d timeout=%b valid=%b expected 31 31 1 0", acts, iter_count, timeout, winner_valid); end
    endtask

    // Starts from the timed-out DONE state so the restart must clear timeout.
    task automatic test_annihilate();
        int cyc, acts, ovl;
        bit exp_flag;
        zero_flags = 4'b0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++;
        if (timeout !== 1'b0 || done !== 1'b0 || iter_count !== 5'd0) begin failures++; $display("[TB] FAIL restart_clear: timeout=%b done=%b iter=%0d expected 0 0 0", timeout, done, iter_count); end
        tick();
        tick();
        zero_flags = 4'b1111;
        wait_done(1'b0, 20, cyc, acts, ovl, exp_flag);
        tests++;
        if (exp_flag || cyc !== 3) begin failures++; $display("[TB] FAIL annihilate_latency: got %0d cycles expected 3 (expired=%b)", cyc, exp_flag); end
        tests++;
        if (winner_valid !== 1'b0 || timeout !== 1'b0 || iter_count !== 5'd1 || winner_idx !== 2'd0) begin failures++; $display("[TB] FAIL annihilate_state: valid=%b timeout=%b iter=%0d idx=%0d expected 0 0 1 0", winner_valid, timeout, iter_count, winner_idx); end
    endtask

    task automatic test_reset_mid_run();
        logic [13:0] outs;
        int cyc, acts, ovl;
        bit exp_flag;
        do_reset();
        zero_flags = 4'b0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 2; t <= 6; t++) tick();
        tests++;
        if (en_calc !== 1'b1 || iter_count !== 5'd1) begin failures++; $display("[TB] FAIL mid_calc: en_calc=%b iter=%0d expected 1 1", en_calc, iter_count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        outs = {ld_init, en_calc, ld_act, busy, done, winner_idx, winner_valid, timeout, iter_count};
        tests++;
        if (outs !== 14'd0) begin failures++; $display("[TB] FAIL mid_reset_outputs: got %h expected 0", outs); end
        zero_flags = 4'b1110;
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++;
        if (ld_init !== 1'b1 || iter_count !== 5'd0) begin failures++; $display("[TB] FAIL mid_restart: ld_init=%b iter=%0d expected 1 0", ld_init, iter_count); end
        wait_done(1'b0, 20, cyc, acts, ovl, exp_flag);
        tests++;
        if (exp_flag || winner_idx !== 2'd0 || winner_valid !== 1'b1 || iter_count !== 5'd0) begin failures++; $display("[TB] FAIL mid_rerun: idx=%0d valid=%b iter=%0d expected 0 1 0", winner_idx, winner_valid, iter_count); end
    endtask

    task automatic test_back_to_back();
        int cyc, acts, ovl;
        bit exp_flag;
        do_reset();
        zero_flags = 4'b0111;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1'b0, 20, cyc, acts, ovl, exp_flag);
        tests++;
        if (exp_flag || winner_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_first: valid=%b expired=%b expected 1 0", winner_valid, exp_flag); end
        zero_flags = 4'b0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++;
        if (done !== 1'b0 || ld_init !== 1'b1 || winner_valid !== 1'b0 || timeout !== 1'b0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL b2b_restart: done=%b ld_init=%b valid=%b timeout=%b busy=%b expected 0 1 0 0 1", done, ld_init, winner_valid, timeout, busy); end
        tick();
        tick();
        tick();
        tests++;
        if (ld_act !== 1'b1) begin failures++; $display("[TB] FAIL b2b_update: ld_act=%b expected 1", ld_act); end
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++;
        if (ld_init !== 1'b0 || en_calc !== 1'b0 || busy !== 1'b1 || iter_count !== 5'd1) begin failures++; $display("[TB] FAIL b2b_ignore_start: ld_init=%b en_calc=%b busy=%b iter=%0d expected 0 0 1 1", ld_init, en_calc, busy, iter_count); end
        zero_flags = 4'b1101;
        tick();
        tests++;
        if (done !== 1'b1 || winner_idx !== 2'd1 || iter_count !== 5'd1) begin failures++; $display("[TB] FAIL b2b_result: done=%b idx=%0d iter=%0d expected 1 1 1", done, winner_idx, iter_count); end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        zero_flags = 4'b0000;
        test_reset();
        test_first_check_winner();
        test_two_iterations();
        test_timeout_short();
        test_timeout_default();
        test_annihilate();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/maxnet_ctrl.md
MAXNET_CTRL -- requirements
Module: maxnet_ctrl

Interface
REQ-001 Parameter MAX_ITER, default 31, maximum number of inhibition iterations before forced termination (legal range 1..31).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 start  input  1  level request to run one competition; sampled only in IDLE and DONE.
REQ-005 zero_flags  input  4  from datapath; bit i = 1 when neuron i activation equals zero.
REQ-006 ld_init  output  1  one-cycle pulse; datapath loads the external inputs into the activation registers.
REQ-007 en_calc  output  1  one-cycle pulse; datapath computes next activations (self minus epsilon times sum of others, clamped at 0) into its temp registers.
REQ-008 ld_act  output  1  one-cycle pulse; datapath copies temp registers into the activation registers.
REQ-009 busy  output  1  high in every state except IDLE and DONE.
REQ-010 done  output  1  high while in DONE.
REQ-011 winner_idx  output  2  index of the single surviving neuron; valid only when done=1 and winner_valid=1.
REQ-012 winner_valid  output  1  with done: exactly one neuron survived.
REQ-013 timeout  output  1  with done: MAX_ITER was reached with two or more survivors.
REQ-014 iter_count  output  5  number of completed update iterations of the current run.

Function
REQ-015 The FSM SHALL have states IDLE, INIT, CHECK, CALC, UPDATE, DONE; all outputs are registered or decoded from state only (Moore).
REQ-016 IDLE: start=1 -> INIT; else remain.
REQ-017 INIT: ld_init=1, iter_count cleared to 0, winner_valid/timeout cleared -> CHECK.
REQ-018 CHECK: nz = number of zero bits in zero_flags; nz<=1 -> DONE; else iter_count==MAX_ITER -> DONE with timeout=1; else -> CALC.
REQ-019 CALC: en_calc=1 -> UPDATE.
REQ-020 UPDATE: ld_act=1, iter_count incremented by 1 -> CHECK.
REQ-021 On the CHECK->DONE transition with nz==1: winner_idx = position of the single 0 bit in zero_flags, winner_valid=1; with nz==0: winner_idx=0, winner_valid=0, timeout=0 (all neurons annihilated).
REQ-022 On timeout exit: winner_valid=0, winner_idx=0, timeout=1.
REQ-023 DONE: done=1, winner_idx/winner_valid/timeout/iter_count held; start=1 -> INIT (restart); else remain.
REQ-024 Latency: start sampled in IDLE at edge k -> INIT at k+1, first CHECK at k+2; each iteration costs 3 cycles (CHECK, CALC, UPDATE); done rises at edge k+3+3*n for n iterations.
REQ-025 start in INIT/CHECK/CALC/UPDATE SHALL be ignored; no queuing.
REQ-026 ld_init, en_calc, ld_act SHALL be mutually exclusive and each exactly one cycle wide per state visit.
REQ-027 iter_count SHALL never exceed MAX_ITER; no wrap-around.
REQ-028 zero_flags SHALL be sampled only in CHECK; values in other states have no effect.

Reset
REQ-029 rst=1 at a rising edge SHALL force IDLE and clear all outputs (ld_init, en_calc, ld_act, busy, done, winner_idx, winner_valid, timeout, iter_count) to 0, regardless of state, including mid-iteration.
REQ-030 rst has priority over start; start high during the reset cycle SHALL not launch a run; a run starts only if start is still high on the first edge after rst deasserts.

Verification
REQ-031 start=1 for 3 cycles, zero_flags=4'b0000 for 2 iterations then 4'b1011 -> INIT, 2 iterations, done=1 at k+9, winner_idx=2, winner_valid=1, iter_count=2.
REQ-032 start pulse with zero_flags=4'b0111 already in first CHECK -> done at k+3, iter_count=0, winner_idx=3, ld_act never pulsed.
REQ-033 MAX_ITER=3, zero_flags held 4'b0000 -> exactly 3 ld_act pulses, done with timeout=1, winner_valid=0, iter_count=3.
REQ-034 zero_flags goes 4'b0000 -> 4'b1111 after first update -> done, winner_valid=0, timeout=0, iter_count=1.
REQ-035 rst asserted 1 cycle during CALC of iteration 2 -> next cycle IDLE, all outputs 0; new start -> fresh run with iter_count restarting at 0.
REQ-036 start held high while in DONE -> re-enters INIT next cycle, done drops, winner_valid/timeout cleared; start pulses during UPDATE -> no effect on sequence.
